// File: rtl/elem_sdiv_by_row_seq_if.sv
// Common fixed-point bundle: format parameters plus clock and reset.
interface fixedp #(
    parameter int WIDTH = 16,
    parameter int SCALE = 8
) (
    input logic clk,
    input logic reset
);
    modport dut (input clk, input reset);
endinterface

// File: rtl/elem_sdiv_by_row_seq.sv
// Sequential element-wise signed fixed-point divide of a matrix by a row vector.
module elem_sdiv_by_row_seq #(
    parameter int ROWS  = 1,
    parameter int COLS  = 1,
    parameter int LANES = 1,
    parameter int WIDTH = 16,
    parameter int SCALE = 8
) (
    fixedp.dut                                   g,
    input  logic                                 start_i,
    input  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] a_i,
    input  logic [COLS-1:0][WIDTH-1:0]           b_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] f_o,
    output logic                                 dz_o,
    output logic                                 ovf_o
);
    localparam int QB   = WIDTH + SCALE;
    localparam int CNTW = $clog2(QB);
    localparam int RIW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CIW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [QB-1:0] QPMAX = QB'((1 << (WIDTH-1)) - 1);
    localparam logic [QB-1:0] QNMAX = QB'(1 << (WIDTH-1));
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    if (COLS % LANES != 0) begin : g_lanes_chk
        $error("COLS must be a multiple of LANES");
    end
    if (g.WIDTH != WIDTH || g.SCALE != SCALE) begin : g_fmt_chk
        $error("fixedp format does not match WIDTH/SCALE");
    end

    typedef enum logic [2:0] {IDLE, LOAD, ITER, STORE, DONE} state_t;

    state_t state_q, state_d;
    logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] a_q, a_d, f_q, f_d;
    logic [COLS-1:0][WIDTH-1:0] b_q, b_d;
    logic [RIW-1:0]  row_q, row_d;
    logic [CIW-1:0]  col_q, col_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [LANES-1:0][QB-1:0]    num_q, num_d;
    logic [LANES-1:0][WIDTH-1:0] rem_q, rem_d;
    logic [LANES-1:0][WIDTH:0]   den_q, den_d;
    logic [LANES-1:0] neg_q, neg_d, zd_q, zd_d, an_q, an_d;
    logic dz_q, dz_d, ovf_q, ovf_d;

    logic [CIW-1:0]   ci;
    logic [WIDTH-1:0] ai, bi, amag;
    logic [WIDTH:0]   be, t;
    logic [QB-1:0]    q;
    logic [WIDTH-1:0] res;
    logic             last;

    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        f_d = f_q;
        row_d = row_q;
        col_d = col_q;
        cnt_d = cnt_q;
        num_d = num_q;
        rem_d = rem_q;
        den_d = den_q;
        neg_d = neg_q;
        zd_d = zd_q;
        an_d = an_q;
        dz_d = dz_q;
        ovf_d = ovf_q;
        ci = '0;
        ai = '0;
        bi = '0;
        amag = '0;
        be = '0;
        t = '0;
        q = '0;
        res = '0;
        last = (row_q == RIW'(ROWS-1)) && (col_q == CIW'(COLS-LANES));
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d = a_i;
                    b_d = b_i;
                    dz_d = 1'b0;
                    ovf_d = 1'b0;
                    row_d = '0;
                    col_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                for (int l = 0; l < LANES; l++) begin
                    ci = CIW'(int'(col_q) + l);
                    ai = a_q[row_q][ci];
                    bi = b_q[ci];
                    amag = ai[WIDTH-1] ? (~ai + 1'b1) : ai;
                    be = {bi[WIDTH-1], bi};
                    num_d[l] = {amag, {SCALE{1'b0}}};
                    den_d[l] = be[WIDTH] ? (~be + 1'b1) : be;
                    rem_d[l] = '0;
                    an_d[l] = ai[WIDTH-1];
                    neg_d[l] = ai[WIDTH-1] ^ bi[WIDTH-1];
                    zd_d[l] = (bi == '0);
                end
                cnt_d = '0;
                state_d = ITER;
            end
            ITER: begin
                // restoring step: quotient bits shift into num from the right
                for (int l = 0; l < LANES; l++) begin
                    t = {rem_q[l], num_q[l][QB-1]};
                    if (t >= den_q[l]) begin
                        rem_d[l] = WIDTH'(t - den_q[l]);
                        num_d[l] = {num_q[l][QB-2:0], 1'b1};
                    end else begin
                        rem_d[l] = t[WIDTH-1:0];
                        num_d[l] = {num_q[l][QB-2:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNTW'(QB-1)) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                for (int l = 0; l < LANES; l++) begin
                    ci = CIW'(int'(col_q) + l);
                    q = num_q[l];
                    if (zd_q[l]) begin
                        res = an_q[l] ? MINV : MAXV;
                        dz_d = 1'b1;
                    end else if (neg_q[l]) begin
                        if (q > QNMAX) begin
                            res = MINV;
                            ovf_d = 1'b1;
                        end else begin
                            res = ~q[WIDTH-1:0] + 1'b1;
                        end
                    end else if (q > QPMAX) begin
                        res = MAXV;
                        ovf_d = 1'b1;
                    end else begin
                        res = q[WIDTH-1:0];
                    end
                    f_d[row_q][ci] = res;
                end
                if (last) begin
                    state_d = DONE;
                end else begin
                    state_d = LOAD;
                    if (col_q == CIW'(COLS-LANES)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + CIW'(LANES);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge g.clk) begin
        if (g.reset) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            f_q <= '0;
            row_q <= '0;
            col_q <= '0;
            cnt_q <= '0;
            num_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            neg_q <= '0;
            zd_q <= '0;
            an_q <= '0;
            dz_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            f_q <= f_d;
            row_q <= row_d;
            col_q <= col_d;
            cnt_q <= cnt_d;
            num_q <= num_d;
            rem_q <= rem_d;
            den_q <= den_d;
            neg_q <= neg_d;
            zd_q <= zd_d;
            an_q <= an_d;
            dz_q <= dz_d;
            ovf_q <= ovf_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign f_o = f_q;
    assign dz_o = dz_q;
    assign ovf_o = ovf_q;
endmodule

// File: tb/tb_elem_sdiv_by_row_seq.sv
// Bench: directed single-lane cases plus randomized 2x4 / 2-lane runs vs arithmetic model.
module tb_elem_sdiv_by_row_seq;
    localparam int W = 16;
    localparam int S = 8;
    localparam int R = 2;
    localparam int C = 4;
    localparam int L = 2;
    localparam int LAT1 = 27;
    localparam int LATB = 105;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fixedp #(.WIDTH(W), .SCALE(S)) g (.clk(clk), .reset(rst));

    logic s1 = 1'b0;
    logic [0:0][0:0][W-1:0] a1 = '0;
    logic [0:0][W-1:0] b1 = '0;
    logic [0:0][0:0][W-1:0] f1;
    logic busy1, done1, dz1, ovf1;

    logic sb = 1'b0;
    logic [R-1:0][C-1:0][W-1:0] ab = '0;
    logic [C-1:0][W-1:0] bb = '0;
    logic [R-1:0][C-1:0][W-1:0] fb;
    logic busyb, doneb, dzb, ovfb;

    elem_sdiv_by_row_seq #(.ROWS(1), .COLS(1), .LANES(1), .WIDTH(W), .SCALE(S)) u_one (
        .g(g), .start_i(s1), .a_i(a1), .b_i(b1),
        .busy_o(busy1), .done_o(done1), .f_o(f1), .dz_o(dz1), .ovf_o(ovf1)
    );

    elem_sdiv_by_row_seq #(.ROWS(R), .COLS(C), .LANES(L), .WIDTH(W), .SCALE(S)) u_big (
        .g(g), .start_i(sb), .a_i(ab), .b_i(bb),
        .busy_o(busyb), .done_o(doneb), .f_o(fb), .dz_o(dzb), .ovf_o(ovfb)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {ovf, dz, f} from plain signed arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint n, d, qq, mx, mn;
        n = longint'($signed(a)) * (longint'(1) <<< S);
        d = longint'($signed(b));
        mx = (longint'(1) <<< (W-1)) - 1;
        mn = -(longint'(1) <<< (W-1));
        if (d == 0) return {2'b01, (a[W-1] ? mn[W-1:0] : mx[W-1:0])};
        qq = n / d;
        if (qq > mx) return {2'b10, mx[W-1:0]};
        if (qq < mn) return {2'b10, mn[W-1:0]};
        return {2'b00, qq[W-1:0]};
    endfunction

    task automatic run1(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ef, input logic edz, input logic eovf,
                        input string tag, input bit poke_done);
        int n;
        a1[0][0] = a;
        b1[0] = b;
        s1 = 1'b1;
        tick();
        s1 = 1'b0;
        a1[0][0] = W'($urandom);
        b1[0] = W'($urandom);
        n = 1;
        while (!done1 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(LAT1));
        chk({tag, "_f"}, 64'(f1[0][0]), 64'(ef));
        chk({tag, "_dz"}, 64'(dz1), 64'(edz));
        chk({tag, "_ovf"}, 64'(ovf1), 64'(eovf));
        if (poke_done) s1 = 1'b1;
        tick();
        s1 = 1'b0;
        chk({tag, "_done1cyc"}, 64'(done1), 64'd0);
        if (poke_done) begin
            chk({tag, "_donestart_ign"}, 64'(busy1), 64'd0);
            tick();
            tick();
            chk({tag, "_dz_hold"}, 64'(dz1), 64'(edz));
        end
    endtask

    logic [R-1:0][C-1:0][W-1:0] exp_f;
    logic exp_dz, exp_ovf;

    task automatic load_big(input bit zero_ok);
        logic [W+1:0] m;
        for (int c = 0; c < C; c++) begin
            bb[c] = W'($urandom);
            if (!zero_ok && bb[c] == '0) bb[c] = 16'h0001;
            if (zero_ok && c == 1) bb[c] = '0;
            if ($urandom_range(0, 1) == 1) bb[c] = W'($signed(bb[c]) >>> 6);
            if (!zero_ok && bb[c] == '0) bb[c] = 16'hFFFF;
        end
        exp_dz = 1'b0;
        exp_ovf = 1'b0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                ab[r][c] = W'($urandom);
                if ($urandom_range(0, 1) == 1) ab[r][c] = W'($signed(ab[r][c]) >>> 5);
                m = model(ab[r][c], bb[c]);
                exp_f[r][c] = m[W-1:0];
                exp_dz |= m[W];
                exp_ovf |= m[W+1];
            end
        end
    endtask

    task automatic scramble_big();
        for (int c = 0; c < C; c++) bb[c] = W'($urandom);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) ab[r][c] = W'($urandom);
    endtask

    task automatic run_big(input string tag, input bit zero_ok);
        int n;
        bit busy_ok;
        load_big(zero_ok);
        sb = 1'b1;
        tick();
        sb = 1'b0;
        scramble_big();
        n = 1;
        busy_ok = 1'b1;
        while (!doneb && n < 400) begin
            if (!busyb) busy_ok = 1'b0;
            if (n == 30) begin
                scramble_big();
                sb = 1'b1;
            end
            tick();
            sb = 1'b0;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(LATB));
        chk({tag, "_busy"}, 64'(busy_ok && busyb), 64'd1);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                chk($sformatf("%s_f%0d%0d", tag, r, c), 64'(fb[r][c]), 64'(exp_f[r][c]));
        chk({tag, "_dz"}, 64'(dzb), 64'(exp_dz));
        chk({tag, "_ovf"}, 64'(ovfb), 64'(exp_ovf));
        tick();
        chk({tag, "_idle"}, 64'(busyb), 64'd0);
    endtask

    initial begin
        int n;
        bit saw_done;
        repeat (3) tick();
        chk("rst_busy", 64'({busy1, busyb}), 64'd0);
        chk("rst_done", 64'({done1, doneb}), 64'd0);
        chk("rst_flags", 64'({dz1, ovf1, dzb, ovfb}), 64'd0);
        chk("rst_f1", 64'(f1), 64'd0);
        chk("rst_fb", 64'(fb == '0), 64'd1);
        rst = 1'b0;
        tick();

        run1(16'h0180, 16'h0080, 16'h0300, 1'b0, 1'b0, "basic", 1'b0);
        run1(16'hFE80, 16'h0080, 16'hFD00, 1'b0, 1'b0, "neg", 1'b0);
        run1(16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0, "trunc", 1'b0);
        run1(16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b0, "dzpos", 1'b1);
        run1(16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b0, "dzneg", 1'b0);
        run1(16'h7F00, 16'h0001, 16'h7FFF, 1'b0, 1'b1, "sat", 1'b0);
        run1(16'h8000, 16'hFF00, 16'h7FFF, 1'b0, 1'b1, "minneg", 1'b0);

        for (int i = 0; i < 4; i++) run_big($sformatf("rnd%0d", i), 1'b0);
        run_big("rndz", 1'b1);

        load_big(1'b0);
        sb = 1'b1;
        tick();
        sb = 1'b0;
        n = 1;
        while (n < 40) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busyb), 64'd0);
        chk("mid_rst_f", 64'(fb == '0), 64'd1);
        chk("mid_rst_flags", 64'({dzb, ovfb, doneb}), 64'd0);
        saw_done = 1'b0;
        repeat (120) begin
            if (doneb || busyb) saw_done = 1'b1;
            tick();
        end
        chk("mid_rst_nodone", 64'(saw_done), 64'd0);

        rst = 1'b1;
        sb = 1'b1;
        tick();
        rst = 1'b0;
        sb = 1'b0;
        tick();
        chk("start_in_rst", 64'(busyb), 64'd0);

        run_big("post_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
